fx_accum_seq: RTL

//  Sequential Q8.8 signed accumulator that drives the team's combinational add/subtract datapath.
//  - Accepts a stream of terms on a valid/ready handshake.
//  - Adds or subtracts each term into a running sum, saturating or wrapping on overflow.
//  - Emits the frame total on a second valid/ready handshake after the term flagged last.
//  - Sits between the ODE step sequencer and the state-update registers (e.g. y += h*k1 + ...).

---
 rtl/fx_pkg.sv | 17 +
 rtl/fx_add_sub_sat.sv | 25 ++
 rtl/fx_accum_seq.sv | 95 +++++++++
 3 files changed

// File: rtl/fx_pkg.sv
// Shared Q8.8 fixed-point types and constants for the accumulator and
// its add/subtract datapath.
package fx_pkg;
  localparam int FX_WIDTH = 16;
  localparam int FX_FRAC  = 8;

  typedef logic signed [FX_WIDTH-1:0] fx_t;

  localparam fx_t FX_MAX = 16'h7FFF;
  localparam fx_t FX_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } acc_state_t;
endpackage

// File: rtl/fx_add_sub_sat.sv
// Combinational two's-complement add/subtract with overflow detection and a
// saturated alternative result; shared with the team's combinational datapath.
module fx_add_sub_sat #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] r_o,
  output logic             ovf_o,
  output logic [WIDTH-1:0] sat_r_o
);
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] b_eff;

  // Subtraction as a + ~b + 1 keeps one adder and one overflow rule.
  assign b_eff = sub_i ? ~b_i : b_i;
  assign r_o   = a_i + b_eff + {{(WIDTH-1){1'b0}}, sub_i};
  assign ovf_o = (~r_o[WIDTH-1] &  a_i[WIDTH-1] &  b_eff[WIDTH-1]) |
                 ( r_o[WIDTH-1] & ~a_i[WIDTH-1] & ~b_eff[WIDTH-1]);
  // On overflow the true result has the sign of a, so clamp toward it.
  assign sat_r_o = ovf_o ? (a_i[WIDTH-1] ? SAT_MIN : SAT_MAX) : r_o;
endmodule

// File: rtl/fx_accum_seq.sv
// Frame accumulator: sums a stream of signed terms, then presents the total,
// sticky overflow flag and beat count on an output handshake.
module fx_accum_seq
  import fx_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);
  if (FRAC >= WIDTH) begin : g_frac_check
    $error("FRAC must be smaller than WIDTH");
  end

  acc_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] sum_r, sum_sat;
  logic             sum_ovf;
  logic             beat_acc, out_fire;

  fx_add_sub_sat #(.WIDTH(WIDTH)) u_add_sub (
    .a_i    (acc_q),
    .b_i    (in_data),
    .sub_i  (in_sub),
    .r_o    (sum_r),
    .ovf_o  (sum_ovf),
    .sat_r_o(sum_sat)
  );

  assign beat_acc = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: if (beat_acc) state_d = in_last ? OUTPUT : ACCUM;
      OUTPUT:      if (out_fire) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Frame datapath: clear on output handshake, fold in each accepted beat.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (out_fire) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (beat_acc) begin
      acc_d = SATURATE ? sum_sat : sum_r;
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
      ovf_d = ovf_q | sum_ovf;
    end
  end

  always_comb begin
    in_ready  = (state_q != OUTPUT);
    out_valid = (state_q == OUTPUT);
    out_data  = acc_q;
    out_ovf   = ovf_q;
    out_count = cnt_q;
  end
endmodule
